// File: rtl/dot_product_seq.sv
// Sequencer for the complex 4-lane dot-product datapath and its result RAM.
// It counts one frame of input samples into the RAM, then streams the results out over a valid/ready handshake.
module dot_product_seq #(
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8,   // results per frame, at most 2**ADDR_WIDTH
  parameter int DP_LAT     = 1    // datapath latency, sample to RAM din (0..4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  busy,
  output logic                  done
);

  // One extra counter bit lets a count reach DEPTH == 2**ADDR_WIDTH without wrapping.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]         LAST_CNT = CW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, FILL, DRAIN, READ, DONE} stateT;

  stateT                 state, stateNext;
  logic [CW-1:0]         accCnt, wrCnt;
  logic [ADDR_WIDTH-1:0] outIdx;
  logic                  outValid;
  logic                  accept, fire;

  assign in_ready  = (state == FILL) && (accCnt < DEPTH_C);
  assign accept    = in_valid & in_ready;
  assign fire      = outValid & out_ready;
  assign w_addr    = wrCnt[ADDR_WIDTH-1:0];
  assign r_addr    = fire ? outIdx + 1'b1 : outIdx;
  assign out_valid = outValid;
  assign out_idx   = outIdx;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // NOTE: every signal written in a combinational block gets a default first, otherwise an untaken path infers a latch.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = FILL;
      FILL:    if (accept && accCnt == LAST_CNT) stateNext = DRAIN;
      DRAIN:   if (wrCnt == DEPTH_C) stateNext = READ;
      READ:    if (fire && outIdx == LAST_IDX) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      accCnt   <= '0;
      wrCnt    <= '0;
      outIdx   <= '0;
      outValid <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == IDLE && start) begin
        accCnt <= '0;
        wrCnt  <= '0;
      end else begin
        if (accept) accCnt <= accCnt + 1'b1;
        if (we)     wrCnt  <= wrCnt + 1'b1;
      end
      // The first READ cycle only issues address 0; valid follows the RAM's one-cycle read.
      if (state == READ) outValid <= !(fire && outIdx == LAST_IDX);
      else               outValid <= 1'b0;
      if (fire) outIdx <= (outIdx == LAST_IDX) ? '0 : outIdx + 1'b1;
    end
  end

  // Write strobe follows each accept by exactly the datapath latency.
  if (DP_LAT == 0) begin : gNoLat
    assign we = accept;
  end else begin : gLat
    logic [DP_LAT-1:0] dly;
    // NOTE: the delay line is reset on purpose, so an in-flight accept cannot write after reset releases.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) dly <= '0;
      else     dly <= (dly << 1) | DP_LAT'(accept);
    end
    assign we = dly[DP_LAT-1];
  end

endmodule

// File: tb/tb_dot_product_seq.sv
// Self-checking bench for dot_product_seq: behavioural datapath/RAM around the DUT,
// a frame-level reference model checked every cycle, and literal per-frame expectations.
module tb_dot_product_seq;
  localparam int AW = 3, DEPTH = 8, DP_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, we, out_valid, busy, done;
  logic [AW-1:0] w_addr, r_addr, out_idx;
  logic [15:0] inData = '0, din, dout;
  logic [15:0] ram [DEPTH];
  logic [15:0] dpPipe [4];

  int checks = 0, errors = 0;
  int rdyMode = 0;    // 0: always ready, 1: random, 2: stall 4 cycles at index 3
  int frameId = 0;

  always #5 clk = ~clk;

  dot_product_seq #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .we(we), .w_addr(w_addr), .r_addr(r_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .busy(busy), .done(done)
  );

  // Datapath stand-in (pure delay) and the RAM with synchronous write and 1-cycle read.
  always @(posedge clk) begin
    dpPipe[0] <= inData;
    for (int i = 1; i < 4; i++) dpPipe[i] <= dpPipe[i-1];
    if (we) ram[w_addr] <= din;
    dout <= ram[r_addr];
  end
  assign din = dpPipe[DP_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer: drives out_ready shortly after each rising edge.
  always @(posedge clk) begin
    static int stallUsed = 0;
    #1;
    if (!busy) stallUsed = 0;
    case (rdyMode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (out_valid && out_idx == 3'd3 && stallUsed < 4) begin
          out_ready = 1'b0;
          stallUsed++;
        end else out_ready = 1'b1;
      end
    endcase
  end

  // Frame-level reference model, checked every cycle on the falling edge.
  typedef enum {M_IDLE, M_FILL, M_WAIT, M_READ, M_DONE} mPhaseT;
  mPhaseT mPhase = M_IDLE;
  logic [7:0]  hist = '0;           // hist[k]: an accept happened k+1 cycles ago
  logic [15:0] samples [DEPTH];
  int accepted = 0, writes = 0, fires = 0, waitCnt = 0;

  always @(negedge clk) begin
    logic expInReady, curAccept, expWe;
    if (rst) begin
      mPhase = M_IDLE; hist = '0; accepted = 0; writes = 0; fires = 0; waitCnt = 0;
    end else begin
      expInReady = (mPhase == M_FILL);
      curAccept  = in_valid && expInReady;
      expWe      = hist[DP_LAT-1];
      if (mPhase == M_WAIT && out_valid === 1'b1) begin
        check("writes_before_read", writes, DEPTH);
        mPhase = M_READ;
      end
      check("in_ready", in_ready, expInReady);
      check("we", we, expWe);
      check("busy", busy, mPhase != M_IDLE);
      check("done", done, mPhase == M_DONE);
      if (expWe) check("w_addr", w_addr, writes % DEPTH);
      if (mPhase == M_READ) begin
        check("out_valid", out_valid, 1);
        check("out_idx", out_idx, fires);
        check("dout", dout, samples[fires]);
        if (!(out_ready && fires == DEPTH - 1))
          check("r_addr", r_addr, out_ready ? (fires + 1) % DEPTH : fires);
      end else begin
        check("out_valid", out_valid, 0);
      end
      if (mPhase == M_WAIT) begin
        check("r_addr_pre_read", r_addr, 0);
        waitCnt++;
        if (waitCnt > 6) begin
          checks++; errors++;
          $display("FAIL read_start: out_valid still 0 after %0d cycles, expected 1", waitCnt);
          mPhase = M_IDLE;
        end
      end
      // Advance the model across the coming rising edge.
      hist = {hist[6:0], curAccept};
      if (expWe) writes++;
      case (mPhase)
        M_IDLE: if (start) begin
          mPhase = M_FILL; accepted = 0; writes = 0; fires = 0; waitCnt = 0;
        end
        M_FILL: if (curAccept) begin
          samples[accepted] = inData;
          accepted++;
          if (accepted == DEPTH) mPhase = M_WAIT;
        end
        M_READ: if (out_ready) begin
          fires++;
          if (fires == DEPTH) mPhase = M_DONE;
        end
        M_DONE: mPhase = M_IDLE;
        default: ;
      endcase
    end
  end

  // Per-frame statistics for literal expectations; cleared whenever frameId changes.
  int lastFrame = -1, cyc = 0;
  int accCnt, weCnt, weRun, maxRun, fireCnt, doneCnt, stallCnt, firstAcc, firstWe, firstWAddr;
  logic prevWe;
  always @(negedge clk) begin
    if (frameId != lastFrame) begin
      lastFrame = frameId;
      accCnt = 0; weCnt = 0; weRun = 0; maxRun = 0; fireCnt = 0; doneCnt = 0;
      stallCnt = 0; firstAcc = -1; firstWe = -1; firstWAddr = -1; prevWe = 1'b0;
    end
    if (!rst) begin
      if (in_valid && in_ready) begin
        accCnt++;
        if (firstAcc < 0) firstAcc = cyc;
      end
      if (we) begin
        weCnt++;
        if (firstWe < 0) begin firstWe = cyc; firstWAddr = int'(w_addr); end
        weRun = prevWe ? weRun + 1 : 1;
        if (weRun > maxRun) maxRun = weRun;
      end
      prevWe = we;
      if (out_valid && out_ready) fireCnt++;
      if (done) doneCnt++;
      if (out_valid && !out_ready && out_idx == 3'd3) stallCnt++;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulseStart();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // pattern 0: always valid, 1: gapped 1,0,1,1,0,0,1 ..., 2: random
  task automatic fillFrame(input int pattern, input int minCyc, input int maxCyc);
    bit gap [7] = '{1, 0, 1, 1, 0, 0, 1};
    int acc = 0, c = 0;
    while (c < minCyc || (acc < DEPTH && c < maxCyc)) begin
      case (pattern)
        0:       in_valid = 1'b1;
        1:       in_valid = gap[c % 7];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      inData = 16'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      tick();
      c++;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input int maxCyc);
    int n = 0;
    while (done !== 1'b1 && n < maxCyc) begin tick(); n++; end
    check("done_reached", done, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_busy", busy, 0);       check("rst_we", we, 0);
    check("rst_in_ready", in_ready, 0); check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);       check("rst_out_idx", out_idx, 0);
    check("rst_w_addr", w_addr, 0);   check("rst_r_addr", r_addr, 0);
    tick(); tick(); rst = 1'b0; tick();

    // Frame 1: in_valid held for 10 cycles, consumer always ready.
    frameId++; rdyMode = 0;
    pulseStart();
    fillFrame(0, 10, 10);
    waitDone(60);
    tick();
    check("f1_accepts", accCnt, 8);        check("f1_we_cycles", weCnt, 8);
    check("f1_we_run", maxRun, 8);         check("f1_we_delay", firstWe - firstAcc, 1);
    check("f1_first_waddr", firstWAddr, 0); check("f1_fires", fireCnt, 8);
    check("f1_done_pulses", doneCnt, 1);   check("f1_busy_after", busy, 0);

    // Frame 2: gapped input, random backpressure.
    frameId++; rdyMode = 1;
    pulseStart();
    fillFrame(1, 0, 60);
    waitDone(200);
    check("f2_accepts", accCnt, 8); check("f2_we_cycles", weCnt, 8); check("f2_fires", fireCnt, 8);

    // Frame 3: stall at index 3, start during READ and coincident with done.
    frameId++; rdyMode = 2;
    pulseStart();
    fillFrame(2, 0, 80);
    for (int n = 0; n < 100 && !(out_valid && out_idx == 3'd5); n++) tick();
    check("f3_reached_idx5", out_idx, 5);
    pulseStart();
    for (int n = 0; n < 100 && done !== 1'b1; n++) tick();
    check("f3_done_seen", done, 1);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("f3_stall_cycles", stallCnt, 4); check("f3_fires", fireCnt, 8);
    check("f3_done_pulses", doneCnt, 1);   check("f3_idle_after", busy, 0);

    // Frame 4: reset right after the 5th accept.
    frameId++; rdyMode = 0;
    pulseStart();
    in_valid = 1'b1;
    begin
      int acc = 0;
      for (int n = 0; n < 40 && acc < 5; n++) begin
        inData = 16'($urandom);
        @(negedge clk);
        if (in_valid && in_ready) acc++;
        if (acc < 5) tick();
      end
    end
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("mid_busy", busy, 0);         check("mid_we", we, 0);
    check("mid_in_ready", in_ready, 0); check("mid_out_valid", out_valid, 0);
    check("mid_done", done, 0);         check("mid_w_addr", w_addr, 0);
    check("mid_out_idx", out_idx, 0);   check("mid_r_addr", r_addr, 0);
    tick(); tick(); rst = 1'b0;
    frameId++;
    repeat (5) tick();
    in_valid = 1'b0;
    check("post_rst_we", weCnt, 0); check("post_rst_accepts", accCnt, 0);

    // Frame 5: clean frame after reset.
    frameId++;
    pulseStart();
    fillFrame(0, 8, 8);
    waitDone(60);
    check("f5_first_waddr", firstWAddr, 0); check("f5_we_cycles", weCnt, 8);
    check("f5_fires", fireCnt, 8);

    // Random frames.
    for (int k = 0; k < 3; k++) begin
      frameId++; rdyMode = 1;
      pulseStart();
      fillFrame(2, 0, 80);
      waitDone(200);
      check("rand_fires", fireCnt, 8);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
